// File: rtl/fp_seq_pkg.sv
// Shared definitions for the double-precision FP memory sequencer:
// state encoding, FP load/store opcodes and default port geometry.
package fp_seq_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  localparam logic [5:0] OP_LDC1 = 6'h35;
  localparam logic [5:0] OP_SDC1 = 6'h3d;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/fp_dmem_seq.sv
// Splits ldc1/sdc1 64-bit accesses into two big-endian word beats on a 32-bit memory port.
// Optional macro FP_DMEM_ALIGN_CHECK_EN rejects requests whose byte address is not 8-aligned.
module fp_dmem_seq
  import fp_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  input  logic                req_write_i,
  input  logic [31:0]         req_addr_i,
  input  logic [2*DATA_W-1:0] wdata_d_i,
  input  logic [DATA_W-1:0]   mem_q_i,
  output logic                mem_sel_o,
  output logic                CEN_o,
  output logic                WEN_o,
  output logic                OEN_o,
  output logic [ADDR_W-1:0]   A_o,
  output logic [DATA_W-1:0]   D_o,
  output logic                stall_o,
  output logic                done_o,
  output logic                fp_we_o,
  output logic [2*DATA_W-1:0] rdata_d_o,
  output logic                misalign_o
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   req_base;
  logic                is_write;
  logic [2*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]   hi_q;
  logic                aligned;
  logic                accept;
  logic                unused_addr;

`ifdef FP_DMEM_ALIGN_CHECK_EN
  assign aligned  = (req_addr_i[2:0] == 3'b000);
  assign req_base = req_addr_i[ADDR_W+1:2];
`else
  // Without the check the pair is forced onto an even word so both beats stay in one pair.
  assign aligned  = 1'b1;
  assign req_base = {req_addr_i[ADDR_W+1:3], 1'b0};
`endif

  assign unused_addr = ^{req_addr_i[31:ADDR_W+2], req_addr_i[2:0]};

  assign accept     = (state == IDLE) && req_valid_i && aligned;
  assign misalign_o = (state == IDLE) && req_valid_i && !aligned;

  // NOTE: every register, including the data latches, is reset so the
  // sequencer restarts cleanly even when reset lands in the middle of a pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      is_write <= 1'b0;
      wdata    <= '0;
      hi_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      state <= state_nxt;
      if (accept) begin
        base     <= req_base;
        is_write <= req_write_i;
        wdata    <= wdata_d_i;
      end
      // Read data for the hi beat arrives the cycle after its address, i.e. during LO.
      if (state == LO && !is_write) hi_q <= mem_q_i;
    end
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    mem_sel_o = 1'b0;
    CEN_o     = 1'b1;
    WEN_o     = 1'b1;
    OEN_o     = 1'b1;
    A_o       = '0;
    D_o       = '0;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    fp_we_o   = 1'b0;
    rdata_d_o = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_o   = 1'b1;
          state_nxt = HI;
        end
      end
      HI: begin
        mem_sel_o = 1'b1;
        CEN_o     = 1'b0;
        A_o       = base;
        stall_o   = 1'b1;
        if (is_write) begin
          WEN_o = 1'b0;
          D_o   = wdata[2*DATA_W-1:DATA_W];
        end else begin
          OEN_o = 1'b0;
        end
        state_nxt = LO;
      end
      LO: begin
        mem_sel_o = 1'b1;
        CEN_o     = 1'b0;
        A_o       = base + ADDR_W'(1);
        if (is_write) begin
          WEN_o     = 1'b0;
          D_o       = wdata[DATA_W-1:0];
          done_o    = 1'b1;
          state_nxt = IDLE;
        end else begin
          OEN_o     = 1'b0;
          stall_o   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        mem_sel_o = 1'b1;
        rdata_d_o = {hi_q, mem_q_i};
        done_o    = 1'b1;
        fp_we_o   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_dmem_seq.sv
// Self-checking bench for fp_dmem_seq: SRAM model, per-cycle expectation queue from a
// transaction-level model, plus hand-computed literal checks on addresses, data and stall length.
module tb_fp_dmem_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [31:0] req_addr;
  logic [63:0] wdata_d;
  logic [31:0] mem_q;
  logic        mem_sel, cen, wen, oen;
  logic [6:0]  a;
  logic [31:0] d;
  logic        stall, done, fp_we, misalign;
  logic [63:0] rdata_d;

  fp_dmem_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
    .wdata_d_i(wdata_d), .mem_q_i(mem_q),
    .mem_sel_o(mem_sel), .CEN_o(cen), .WEN_o(wen), .OEN_o(oen),
    .A_o(a), .D_o(d), .stall_o(stall), .done_o(done), .fp_we_o(fp_we),
    .rdata_d_o(rdata_d), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mem_sel, cen, wen, oen, stall, done, fp_we, misalign;
    logic [6:0]  a;
    logic [31:0] d;
    logic [63:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] sram   [128];
  logic [31:0] ref_mem[128];
  int          a_log[$];
  int          n_pass = 0, n_total = 0;
  int          stall_cnt = 0, fp_cnt = 0, exp_fp = 0;
  logic [63:0] last_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.mem_sel = 0; e.cen = 1; e.wen = 1; e.oen = 1;
    e.stall = 0; e.done = 0; e.fp_we = 0; e.misalign = 0;
    e.a = '0; e.d = '0; e.rdata = '0;
    return e;
  endfunction

  // Synchronous-read SRAM; non-read cycles present junk on Q.
  always @(posedge clk) begin
    if (!cen && !wen) sram[a] <= d;
    if (!cen && !oen) mem_q <= sram[a];
    else              mem_q <= $urandom;
  end

  // Single compare process plus monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!cen) a_log.push_back(int'(a));
      if (stall) stall_cnt++;
      if (fp_we) begin fp_cnt++; last_rdata = rdata_d; end
    end
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("mem_sel", mem_sel, e.mem_sel);
      check("CEN", cen, e.cen);
      check("WEN", wen, e.wen);
      check("OEN", oen, e.oen);
      check("stall", stall, e.stall);
      check("done", done, e.done);
      check("fp_we", fp_we, e.fp_we);
      check("misalign", misalign, e.misalign);
      check("rdata_d", rdata_d, e.rdata);
      if (!e.cen) check("A", a, e.a);
      if (!e.wen) check("D", d, e.d);
    end
  end

  task automatic step(input logic v, input logic w, input logic [31:0] ad,
                      input logic [63:0] wd, input exp_t e);
    @(posedge clk);
    #1;
    req_valid = v; req_write = w; req_addr = ad; wdata_d = wd;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 64'h0, idle_exp());
  endtask

  // Transaction model: one request -> expected outputs for every cycle it occupies.
  // Inputs other than req_valid/addr are scrambled after accept to show they are not resampled.
  task automatic run_op(input logic w, input logic [31:0] addr, input logic [63:0] wd,
                        input bit abort_after_hi);
    exp_t e;
    int   base, nb;
`ifdef FP_DMEM_ALIGN_CHECK_EN
    if (addr % 8 != 0) begin
      e = idle_exp(); e.misalign = 1;
      step(1'b1, w, addr, wd, e);
      return;
    end
`endif
    base = int'(addr / 4) % 128;
`ifndef FP_DMEM_ALIGN_CHECK_EN
    base = base - (base % 2);
`endif
    nb = (base + 1) % 128;
    e = idle_exp(); e.stall = 1;
    step(1'b1, w, addr, wd, e);
    e = idle_exp(); e.mem_sel = 1; e.cen = 0; e.a = 7'(base); e.stall = 1;
    if (w) begin e.wen = 0; e.d = wd[63:32]; end
    else e.oen = 0;
    step(1'b1, ~w, addr, ~wd, e);
    if (abort_after_hi) return;
    e = idle_exp(); e.mem_sel = 1; e.cen = 0; e.a = 7'(nb);
    if (w) begin e.wen = 0; e.d = wd[31:0]; e.done = 1; end
    else begin e.oen = 0; e.stall = 1; end
    step(1'b1, ~w, addr, ~wd, e);
    if (w) begin
      ref_mem[base] = wd[63:32];
      ref_mem[nb]   = wd[31:0];
    end else begin
      e = idle_exp(); e.mem_sel = 1; e.done = 1; e.fp_we = 1;
      e.rdata = {ref_mem[base], ref_mem[nb]};
      step(1'b1, w, addr, ~wd, e);
      exp_fp++;
    end
  endtask

  task automatic clear_logs();
    a_log.delete();
    stall_cnt = 0;
  endtask

  task automatic check_a2(input string nm, input int a0, input int a1);
    check({nm, "_beats"}, a_log.size(), 2);
    check({nm, "_A0"}, a_log[0], a0);
    check({nm, "_A1"}, a_log[1], a1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin sram[i] = '0; ref_mem[i] = '0; end
    mem_q = '0;
    req_valid = 0; req_write = 0; req_addr = '0; wdata_d = '0;
    rst_n = 0;
    #3;
    check("rst_CEN", cen, 1'b1);
    check("rst_WEN", wen, 1'b1);
    check("rst_OEN", oen, 1'b1);
    check("rst_A", a, 7'd0);
    check("rst_D", d, 32'd0);
    check("rst_mem_sel", mem_sel, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fp_we", fp_we, 1'b0);
    check("rst_misalign", misalign, 1'b0);
    check("rst_rdata", rdata_d, 64'd0);
    #9 rst_n = 1;

    sram[16]  = 32'h400921FB; ref_mem[16]  = 32'h400921FB;
    sram[17]  = 32'h54442D18; ref_mem[17]  = 32'h54442D18;
    sram[126] = 32'hCAFEF00D; ref_mem[126] = 32'hCAFEF00D;
    sram[127] = 32'h12345678; ref_mem[127] = 32'h12345678;
    idle(2);

    // Load pi from 0x40
    clear_logs();
    run_op(1'b0, 32'h40, 64'h0, 0);
    idle(2);
    check("ld_rdata", last_rdata, 64'h400921FB54442D18);
    check("ld_stall_cycles", stall_cnt, 3);
    check_a2("ld", 16, 17);

    // Store 1.0 to 0x40
    clear_logs();
    run_op(1'b1, 32'h40, 64'h3FF00000_00000000, 0);
    idle(2);
    check("st_mem16", sram[16], 32'h3FF00000);
    check("st_mem17", sram[17], 32'h00000000);
    check("st_stall_cycles", stall_cnt, 2);
    check_a2("st", 16, 17);

    // Back-to-back sdc1 then ldc1 at 0x80
    clear_logs();
    run_op(1'b1, 32'h80, 64'h01234567_89ABCDEF, 0);
    run_op(1'b0, 32'h80, 64'h0, 0);
    idle(2);
    check("b2b_rdata", last_rdata, 64'h0123456789ABCDEF);
    check("b2b_stall_cycles", stall_cnt, 5);
    check("b2b_beats", a_log.size(), 4);
    check("b2b_A0", a_log[0], 32);
    check("b2b_A1", a_log[1], 33);
    check("b2b_A2", a_log[2], 32);
    check("b2b_A3", a_log[3], 33);

    // Top of memory
    clear_logs();
    run_op(1'b0, 32'h1F8, 64'h0, 0);
    idle(2);
    check_a2("top", 126, 127);
    check("top_rdata", last_rdata, 64'hCAFEF00D12345678);

    // Odd-word and misaligned requests
    clear_logs();
    run_op(1'b0, 32'h1FC, 64'h0, 0);
    idle(2);
`ifdef FP_DMEM_ALIGN_CHECK_EN
    check("odd_beats", a_log.size(), 0);
    check("odd_stall_cycles", stall_cnt, 0);
`else
    check_a2("odd", 126, 127);
    check("odd_rdata", last_rdata, 64'hCAFEF00D12345678);
`endif
    clear_logs();
    run_op(1'b0, 32'h44, 64'h0, 0);
    idle(2);
`ifdef FP_DMEM_ALIGN_CHECK_EN
    check("mis_beats", a_log.size(), 0);
    check("mis_stall_cycles", stall_cnt, 0);
`else
    check_a2("mis", 16, 17);
    check("mis_rdata", last_rdata, 64'h3FF0000000000000);
`endif

    // Reset during the LO beat of a load
    run_op(1'b0, 32'h40, 64'h0, 1);
    @(posedge clk);
    #1 req_valid = 0;
    #2 rst_n = 0;
    #1;
    check("mid_rst_CEN", cen, 1'b1);
    check("mid_rst_WEN", wen, 1'b1);
    check("mid_rst_OEN", oen, 1'b1);
    check("mid_rst_mem_sel", mem_sel, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_fp_we", fp_we, 1'b0);
    @(posedge clk);
    #2 rst_n = 1;
    idle(2);
    check("mid_rst_fp_we_count", fp_cnt, exp_fp);

    // Normal traffic after reset
    clear_logs();
    run_op(1'b1, 32'h48, 64'hDEADBEEF_A5A55A5A, 0);
    run_op(1'b0, 32'h48, 64'h0, 0);
    idle(2);
    check("post_rst_rdata", last_rdata, 64'hDEADBEEFA5A55A5A);
    check("post_rst_stall_cycles", stall_cnt, 5);
    check("fp_we_count", fp_cnt, exp_fp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
